// File: rtl/alarm_key_entry.sv
// Alarm-time keypad entry: collects four BCD digits as hh:mm,
// validates them on SET and strobes the alarm register load.
module alarm_key_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key,
    output logic [3:0] new_alarm_ms_hr,
    output logic [3:0] new_alarm_ls_hr,
    output logic [3:0] new_alarm_ms_min,
    output logic [3:0] new_alarm_ls_min,
    output logic       load_new_alarm,
    output logic       entry_busy,
    output logic       entry_error,
    output logic [2:0] digit_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] timer;
    logic        is_digit;
    logic        is_set;
    logic        is_clear;
    logic [7:0]  hours;
    logic        time_ok;

    // Key classification; codes C-F fall through every branch.
    always_comb begin
        is_digit = key_valid && (key <= 4'd9);
        is_set   = key_valid && (key == 4'hA);
        is_clear = key_valid && (key == 4'hB);
    end

    // Range check of the buffered time as a 24-hour hh:mm value.
    always_comb begin
        hours   = 8'(new_alarm_ms_hr) * 8'd10 + 8'(new_alarm_ls_hr);
        time_ok = (new_alarm_ms_hr <= 4'd2) && (new_alarm_ls_hr <= 4'd9)
               && (hours <= 8'd23)
               && (new_alarm_ms_min <= 4'd5) && (new_alarm_ls_min <= 4'd9);
    end

    // Entry FSM with registered buffer, count, timer and strobes.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state            <= IDLE;
            timer            <= '0;
            new_alarm_ms_hr  <= '0;
            new_alarm_ls_hr  <= '0;
            new_alarm_ms_min <= '0;
            new_alarm_ls_min <= '0;
            digit_count      <= '0;
            load_new_alarm   <= 1'b0;
            entry_busy       <= 1'b0;
            entry_error      <= 1'b0;
        end else begin
            load_new_alarm <= 1'b0;
            entry_error    <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (is_digit) begin
                        new_alarm_ms_hr  <= '0;
                        new_alarm_ls_hr  <= '0;
                        new_alarm_ms_min <= '0;
                        new_alarm_ls_min <= key;
                        digit_count      <= 3'd1;
                        state            <= ENTRY;
                        entry_busy       <= 1'b1;
                    end else if (is_clear) begin
                        new_alarm_ms_hr  <= '0;
                        new_alarm_ls_hr  <= '0;
                        new_alarm_ms_min <= '0;
                        new_alarm_ls_min <= '0;
                        digit_count      <= '0;
                    end
                end
                ENTRY: begin
                    if (is_digit) begin
                        timer            <= '0;
                        new_alarm_ms_hr  <= new_alarm_ls_hr;
                        new_alarm_ls_hr  <= new_alarm_ms_min;
                        new_alarm_ms_min <= new_alarm_ls_min;
                        new_alarm_ls_min <= key;
                        if (digit_count != 3'd4)
                            digit_count <= digit_count + 3'd1;
                    end else if (is_set && digit_count == 3'd4 && time_ok) begin
                        timer          <= '0;
                        state          <= LOAD;
                        load_new_alarm <= 1'b1;
                    end else if (is_set || is_clear
                                 || (!key_valid && timer == TIMER_LAST)) begin
                        // Rejected SET, CLEAR and timeout all abandon
                        // the entry; only the rejected SET flags it.
                        timer            <= '0;
                        new_alarm_ms_hr  <= '0;
                        new_alarm_ls_hr  <= '0;
                        new_alarm_ms_min <= '0;
                        new_alarm_ls_min <= '0;
                        digit_count      <= '0;
                        state            <= IDLE;
                        entry_busy       <= 1'b0;
                        entry_error      <= is_set;
                    end else if (!key_valid) begin
                        timer <= timer + 16'd1;
                    end
                end
                LOAD: begin
                    state      <= IDLE;
                    entry_busy <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    entry_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_key_entry.sv
// Randomised scoreboard bench for alarm_key_entry against a
// digit-queue reference model.
module tb_alarm_key_entry;

    localparam int TO = 8;
    localparam logic [3:0] K_SET = 4'hA;
    localparam logic [3:0] K_CLR = 4'hB;

    typedef struct packed {
        logic [15:0] digs;
        logic [2:0]  cnt;
        logic        busy;
        logic        load;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        is_load;
        logic [15:0] digs;
    } ev_t;

    logic       clock;
    logic       reset;
    logic       key_valid;
    logic [3:0] key;
    logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
    logic       load_new_alarm, entry_busy, entry_error;
    logic [2:0] digit_count;

    int checks = 0;
    int failures = 0;

    exp_t cyc_q[$];
    ev_t  ev_q[$];

    // Reference model: digits typed so far (last four kept), a mode
    // and a count of consecutive key-less cycles while entering.
    logic [3:0] d[$];
    int mode = 0;
    int idle_run = 0;

    alarm_key_entry #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .key_valid(key_valid),
        .key(key),
        .new_alarm_ms_hr(ms_hr),
        .new_alarm_ls_hr(ls_hr),
        .new_alarm_ms_min(ms_min),
        .new_alarm_ls_min(ls_min),
        .load_new_alarm(load_new_alarm),
        .entry_busy(entry_busy),
        .entry_error(entry_error),
        .digit_count(digit_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [15:0] model_digs();
        logic [15:0] r;
        r = '0;
        foreach (d[i]) r = {r[11:0], d[i]};
        return r;
    endfunction

    function automatic bit model_time_ok();
        int hh;
        int mm;
        if (d.size() != 4) return 0;
        hh = int'(d[0]) * 10 + int'(d[1]);
        mm = int'(d[2]) * 10 + int'(d[3]);
        return (hh <= 23) && (mm <= 59);
    endfunction

    // One clock of stimulus: apply inputs, advance the model to the
    // state expected after the coming edge, queue the expectations.
    task automatic step(input bit rv, input bit kv, input logic [3:0] k);
        exp_t e;
        ev_t  ev;
        bit   ld;
        bit   er;
        ld = 0;
        er = 0;
        reset = rv;
        key_valid = kv;
        key = k;
        if (!rv) begin
            d.delete();
            mode = 0;
            idle_run = 0;
        end else if (mode == 2) begin
            mode = 0;
        end else if (mode == 0) begin
            if (kv && k <= 4'd9) begin
                d.delete();
                d.push_back(k);
                mode = 1;
                idle_run = 0;
            end else if (kv && k == K_CLR) begin
                d.delete();
            end
        end else begin
            if (kv && k <= 4'd9) begin
                idle_run = 0;
                d.push_back(k);
                if (d.size() > 4) void'(d.pop_front());
            end else if (kv && k == K_SET) begin
                idle_run = 0;
                if (model_time_ok()) begin
                    mode = 2;
                    ld = 1;
                end else begin
                    d.delete();
                    mode = 0;
                    er = 1;
                end
            end else if (kv && k == K_CLR) begin
                idle_run = 0;
                d.delete();
                mode = 0;
            end else if (!kv) begin
                if (idle_run + 1 == TO) begin
                    d.delete();
                    mode = 0;
                    idle_run = 0;
                end else begin
                    idle_run++;
                end
            end
        end
        e.digs = model_digs();
        e.cnt  = 3'(d.size());
        e.busy = (mode != 0);
        e.load = ld;
        e.err  = er;
        cyc_q.push_back(e);
        if (ld || er) begin
            ev.is_load = ld;
            ev.digs = e.digs;
            ev_q.push_back(ev);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        step(1, 1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 4'h0);
    endtask

    // Monitor: per-cycle output check plus strobe scoreboard.
    always @(negedge clock) begin
        exp_t g;
        exp_t x;
        ev_t  ev;
        g = {ms_hr, ls_hr, ms_min, ls_min, digit_count,
             entry_busy, load_new_alarm, entry_error};
        if (cyc_q.size() > 0) begin
            x = cyc_q.pop_front();
            checks++;
            if (g !== x) begin
                failures++;
                $display("FAIL cycle t=%0t got=%h exp=%h", $time, g, x);
            end
        end
        if (load_new_alarm === 1'b1 || entry_error === 1'b1) begin
            checks++;
            if (ev_q.size() == 0) begin
                failures++;
                $display("FAIL strobe unexpected t=%0t load=%b err=%b",
                         $time, load_new_alarm, entry_error);
            end else begin
                ev = ev_q.pop_front();
                if (load_new_alarm !== ev.is_load
                    || entry_error !== !ev.is_load
                    || g.digs !== ev.digs) begin
                    failures++;
                    $display("FAIL strobe t=%0t got=%b%b/%h exp_load=%b/%h",
                             $time, load_new_alarm, entry_error, g.digs,
                             ev.is_load, ev.digs);
                end
            end
        end
    end

    initial begin
        int r;
        reset = 1'b0;
        key_valid = 1'b0;
        key = 4'h0;
        step(0, 0, 4'h0);
        step(0, 1, 4'h3);

        press(0); press(6); press(4); press(5); press(K_SET);
        idle(2);

        press(2); press(3); press(5); press(9); press(K_SET);
        idle(1);
        press(2); press(4); press(0); press(0); press(K_SET);
        idle(1);

        press(1); press(2); press(3); press(K_SET);
        press(9); press(1); press(2); press(3); press(0); press(K_SET);
        idle(1);

        press(1); press(7); idle(TO);
        press(1); press(7); idle(TO - 1); press(3);
        idle(2); press(K_CLR);

        press(1); press(2); press(K_CLR);
        press(1); press(2); press(4'hE); press(4'hF); press(K_SET);
        press(K_SET); press(4'hC);

        press(0); press(6); press(4); press(5); press(K_SET);
        step(0, 1, 4'h1);
        press(0); press(6); press(4); press(5);
        step(0, 1, K_SET);
        press(1); press(2); press(3); press(4); press(K_SET);
        press(7); press(K_SET);

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) step(0, $urandom_range(0, 1), 4'($urandom_range(0, 15)));
            else if (r < 4) idle(TO + $urandom_range(0, 2) - 1);
            else if (r < 40) step(1, 0, 4'($urandom_range(0, 15)));
            else if (r < 80) press(4'($urandom_range(0, 9)));
            else if (r < 88) press(K_SET);
            else if (r < 92) press(K_CLR);
            else press(4'($urandom_range(12, 15)));
        end

        idle(2);
        @(negedge clock);
        #1;
        checks++;
        if (ev_q.size() != 0 || cyc_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d/%0d exp=0/0", ev_q.size(), cyc_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
